// File: rtl/display_buttons_reader.sv
// Scans a 74HC165-style PISO button register and publishes an active-high button word.
// Define DISPLAY_BUTTONS_DEBOUNCE_EN to require two identical consecutive scans before buttons updates.
module display_buttons_reader #(
  parameter int NUM_BITS      = 8,
  parameter int CLK_DIV       = 25,
  parameter int SCAN_INTERVAL = 50000,
  parameter int INVERT_INPUT  = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_shift_out,
  output logic                o_shift_load,
  output logic                o_shift_clkin,
  output logic [NUM_BITS-1:0] o_buttons,
  output logic                o_scan_done,
  output logic                o_changed
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam int IW = (SCAN_INTERVAL > 0) ? $clog2(SCAN_INTERVAL + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(NUM_BITS - 1);
  localparam logic [IW-1:0] IDLE_CNT  = IW'(SCAN_INTERVAL);
  localparam logic          INV       = (INVERT_INPUT != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_LOW, S_HIGH, S_PUBLISH
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_sync;
  logic [DW-1:0]       r_div;
  logic [BW-1:0]       r_bits;
  logic [IW-1:0]       r_idle;
  logic [NUM_BITS-1:0] r_shreg;
  logic [NUM_BITS-1:0] r_buttons;
  logic                r_shift_load;
  logic                r_shift_clkin;
  logic                r_scan_done;
  logic                r_changed;
  logic                w_div_last;
  logic                w_idle_expired;
  logic                w_sample;
  logic                w_bit;
  logic                w_update;
  logic                w_publish;

  assign w_div_last     = (r_div == DIV_LAST);
  assign w_idle_expired = (r_idle >= IDLE_CNT);
  assign w_sample       = (r_state == S_LOW) && w_div_last;
  assign w_bit          = r_sync[1] ^ INV;
  assign w_publish      = (r_state == S_PUBLISH);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_idle_expired && i_enable) w_next = S_LOAD;
      S_LOAD:    if (w_div_last) w_next = S_SETTLE;
      S_SETTLE:  if (w_div_last) w_next = S_LOW;
      S_LOW:     if (w_div_last) w_next = (r_bits == BITS_LAST) ? S_PUBLISH : S_HIGH;
      S_HIGH:    if (w_div_last) w_next = S_LOW;
      // A zero interval chains straight into the next load.
      S_PUBLISH: w_next = ((SCAN_INTERVAL == 0) && i_enable) ? S_LOAD : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

`ifdef DISPLAY_BUTTONS_DEBOUNCE_EN
  logic [NUM_BITS-1:0] r_prev_raw;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prev_raw <= '0;
    end else if (w_publish) begin
      r_prev_raw <= r_shreg;
    end
  end

  assign w_update = (r_shreg == r_prev_raw);
`else
  assign w_update = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync        <= '0;
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_bits        <= '0;
      r_idle        <= IDLE_CNT;
      r_shreg       <= '0;
      r_buttons     <= '0;
      r_shift_load  <= 1'b1;
      r_shift_clkin <= 1'b0;
      r_scan_done   <= 1'b0;
      r_changed     <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_shift_out};
      r_state <= w_next;

      if ((w_next != r_state) || (r_state == S_IDLE)) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DW'(1);
      end

      // Pin outputs are decoded from the next state so they line up with r_state.
      r_shift_load  <= (w_next != S_LOAD);
      r_shift_clkin <= (w_next == S_HIGH);

      if (w_publish) begin
        r_idle <= IW'(1);
      end else if ((r_state == S_IDLE) && !w_idle_expired) begin
        r_idle <= r_idle + IW'(1);
      end

      if (r_state == S_LOAD) begin
        r_bits <= '0;
      end else if (w_sample) begin
        r_shreg <= {r_shreg[NUM_BITS-2:0], w_bit};
        r_bits  <= r_bits + BW'(1);
      end

      r_scan_done <= w_publish;
      r_changed   <= w_publish && w_update && (r_shreg != r_buttons);
      if (w_publish && w_update) begin
        r_buttons <= r_shreg;
      end
    end
  end

  assign o_shift_load  = r_shift_load;
  assign o_shift_clkin = r_shift_clkin;
  assign o_buttons     = r_buttons;
  assign o_scan_done   = r_scan_done;
  assign o_changed     = r_changed;

endmodule
